// File: rtl/coefficient_decoder.sv
// Turns JPEG run/size symbols plus serial amplitude bits into run/coefficient pairs with DC prediction.
// One symbol per size+2 cycles; rs_ready only in IDLE, bit_ready only in AMP, no output backpressure.
module coefficient_decoder (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rs_symbol,
  input  logic       rs_valid,
  output logic       rs_ready,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic       bit_ready,
  input  logic       dc_clear,
  output logic [3:0] r_value,
  output logic [7:0] coefficient,
  output logic       is_new_coefficient,
  output logic       error
);

  typedef enum logic [1:0] {IDLE, AMP, CALC} state_t;

  state_t             state;
  logic [3:0]         run, size, bit_cnt;
  logic [10:0]        amp;
  logic [6:0]         pos;
  logic signed [15:0] pred;
  logic               clr_pend;

  logic [3:0]         rs_run, rs_size;
  logic [7:0]         next_pos_chk, calc_pos;
  logic [15:0]        amp_ext;
  logic signed [16:0] mask, amp_v, dc_sum;
  logic               sym_err;

  function automatic logic [7:0] sat8(input logic signed [16:0] x);
    if (x > 17'sd127)       return 8'h7f;
    else if (x < -17'sd128) return 8'h80;
    else                    return x[7:0];
  endfunction

  assign rs_ready  = (state == IDLE) && !error;
  assign bit_ready = (state == AMP);
  assign rs_run    = rs_symbol[7:4];
  assign rs_size   = rs_symbol[3:0];

  // Amplitude decode: a leading 0 marks a negative value offset by 2^s-1.
  always_comb begin
    amp_ext      = {5'd0, amp};
    mask         = (17'sd1 <<< size) - 17'sd1;
    amp_v        = 17'sd0;
    if (size != 4'd0) begin
      if (amp_ext[size - 4'd1]) amp_v = $signed({6'd0, amp});
      else                      amp_v = $signed({6'd0, amp}) - mask;
    end
    dc_sum       = $signed({pred[15], pred}) + amp_v;
    calc_pos     = {1'b0, pos} + {4'd0, run} + 8'd1;
    next_pos_chk = {1'b0, pos} + {4'd0, rs_run} + 8'd1;
  end

  always_comb begin
    sym_err = 1'b0;
    if (pos == 7'd0) begin
      sym_err = (rs_run != 4'd0) || (rs_size > 4'd11);
    end else if (rs_symbol != 8'h00) begin
      if (rs_size == 4'd0) sym_err = (rs_run != 4'hF);
      else                 sym_err = (rs_size > 4'd10);
      if (next_pos_chk > 8'd64) sym_err = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      run                <= 4'd0;
      size               <= 4'd0;
      bit_cnt            <= 4'd0;
      amp                <= 11'd0;
      pos                <= 7'd0;
      pred               <= 16'sd0;
      clr_pend           <= 1'b0;
      r_value            <= 4'd0;
      coefficient        <= 8'd0;
      is_new_coefficient <= 1'b0;
      error              <= 1'b0;
    end else begin
      is_new_coefficient <= 1'b0;
      if (dc_clear) clr_pend <= 1'b1;
      case (state)
        IDLE: begin
          // Clearing here, before CALC, makes a same-cycle DC add to zero.
          if (clr_pend && pos == 7'd0) begin
            pred <= 16'sd0;
            if (!dc_clear) clr_pend <= 1'b0;
          end
          if (rs_valid && rs_ready) begin
            if (sym_err) begin
              error <= 1'b1;
            end else begin
              run     <= rs_run;
              size    <= rs_size;
              bit_cnt <= rs_size;
              amp     <= 11'd0;
              state   <= (rs_size == 4'd0) ? CALC : AMP;
            end
          end
        end
        AMP: begin
          if (bit_valid) begin
            amp     <= {amp[9:0], bit_in};
            bit_cnt <= bit_cnt - 4'd1;
            if (bit_cnt == 4'd1) state <= CALC;
          end
        end
        CALC: begin
          is_new_coefficient <= 1'b1;
          state              <= IDLE;
          if (pos == 7'd0) begin
            r_value     <= 4'd0;
            coefficient <= sat8(dc_sum);
            pred        <= dc_sum[15:0];
            pos         <= 7'd1;
          end else begin
            r_value     <= run;
            coefficient <= sat8(amp_v);
            if (run == 4'd0 && size == 4'd0) pos <= 7'd0;
            else if (calc_pos == 8'd64)      pos <= 7'd0;
            else                             pos <= calc_pos[6:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coefficient_decoder.sv
// Bench for coefficient_decoder: directed vector table, corner sequences, random symbols vs a model.
module tb_coefficient_decoder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rs_symbol = 8'd0;
  logic       rs_valid = 1'b0, bit_in = 1'b0, bit_valid = 1'b0, dc_clear = 1'b0;
  logic       rs_ready, bit_ready, is_new_coefficient, error;
  logic [3:0] r_value;
  logic [7:0] coefficient;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_pos = 0, m_pred = 0;
  bit m_clr = 1'b0;

  coefficient_decoder dut (
    .clk(clk), .rst(rst), .rs_symbol(rs_symbol), .rs_valid(rs_valid), .rs_ready(rs_ready),
    .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready), .dc_clear(dc_clear),
    .r_value(r_value), .coefficient(coefficient), .is_new_coefficient(is_new_coefficient),
    .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  rs;
    logic [10:0] bits;
    bit          clr;
    int          r;
    int          c;
    int          pos;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; rs_valid = 1'b0; bit_valid = 1'b0; dc_clear = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_pos = 0; m_pred = 0; m_clr = 1'b0;
  endtask

  task automatic pulse_clear();
    dc_clear = 1'b1;
    @(negedge clk);
    dc_clear = 1'b0;
  endtask

  // Called at a negedge; returns at a negedge after the strobe (or after the timeout).
  task automatic send_sym(input logic [7:0] rs, input logic [10:0] bits, input int gap,
                          output bit got, output int lat, output int r, output int c);
    int s;
    s = int'(rs[3:0]);
    rs_symbol = rs; rs_valid = 1'b1;
    @(negedge clk);
    rs_valid = 1'b0;
    for (int i = s - 1; i >= 0; i--) begin
      bit_valid = 1'b0;
      repeat (gap) @(negedge clk);
      bit_valid = 1'b1; bit_in = bits[i];
      @(negedge clk);
    end
    bit_valid = 1'b0;
    got = 1'b0; lat = 0; r = 0; c = 0;
    while (lat < 6 && !got) begin
      @(negedge clk);
      lat++;
      if (is_new_coefficient) begin
        got = 1'b1;
        r   = int'(r_value);
        c   = int'($signed(coefficient));
      end
    end
    if (got) begin
      @(negedge clk);
      chk("strobe_one_cycle", int'(is_new_coefficient), 0);
    end
  endtask

  function automatic int sat8(input int x);
    if (x > 127) return 127;
    if (x < -128) return -128;
    return x;
  endfunction

  // Applies one legal symbol to the model and returns the expected output pair.
  task automatic model_sym(input logic [7:0] rs, input int amp, output int er, output int ec);
    int s, run, v, sum;
    s = int'(rs[3:0]); run = int'(rs[7:4]);
    if (s == 0) v = 0;
    else if (amp >= (1 << (s - 1))) v = amp;
    else v = amp - ((1 << s) - 1);
    if (m_pos == 0) begin
      if (m_clr) begin m_pred = 0; m_clr = 1'b0; end
      sum = m_pred + v;
      ec = sat8(sum); er = 0;
      m_pred = sum & 16'hFFFF;
      if (m_pred >= 32768) m_pred -= 65536;
      m_pos = 1;
    end else if (rs == 8'h00) begin
      er = 0; ec = 0; m_pos = 0;
    end else begin
      er = run; ec = sat8(v);
      m_pos = m_pos + run + 1;
      if (m_pos == 64) m_pos = 0;
    end
  endtask

  initial begin
    bit got;
    int lat, r, c, er, ec, s, run, amp, pick, lim;
    logic [7:0] rs;

    tbl[0]  = '{8'h03, 11'b101,        1'b0, 0,  5,    1};
    tbl[1]  = '{8'h00, 11'd0,          1'b0, 0,  0,    0};
    tbl[2]  = '{8'h02, 11'b01,         1'b0, 0,  3,    1};
    tbl[3]  = '{8'h00, 11'd0,          1'b0, 0,  0,    0};
    tbl[4]  = '{8'h08, 11'b11111111,   1'b1, 0,  127,  1};
    tbl[5]  = '{8'h00, 11'd0,          1'b1, 0,  0,    0};
    tbl[6]  = '{8'h00, 11'd0,          1'b0, 0,  0,    1};
    tbl[7]  = '{8'hF0, 11'd0,          1'b0, 15, 0,    17};
    tbl[8]  = '{8'h25, 11'b00000,      1'b0, 2,  -31,  20};
    tbl[9]  = '{8'h1A, 11'b1000000000, 1'b0, 1,  127,  22};
    tbl[10] = '{8'h0A, 11'd0,          1'b0, 0,  -128, 23};
    tbl[11] = '{8'h11, 11'b0,          1'b0, 1,  -1,   25};
    tbl[12] = '{8'h00, 11'd0,          1'b0, 0,  0,    0};

    do_reset();
    chk("rst_rs_ready", int'(rs_ready), 1);
    chk("rst_bit_ready", int'(bit_ready), 0);
    chk("rst_strobe", int'(is_new_coefficient), 0);
    chk("rst_r", int'(r_value), 0);
    chk("rst_c", int'(coefficient), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_pos", int'(dut.pos), 0);
    chk("rst_pred", int'(dut.pred), 0);

    foreach (tbl[i]) begin
      if (tbl[i].clr) pulse_clear();
      send_sym(tbl[i].rs, tbl[i].bits, 0, got, lat, r, c);
      chk($sformatf("tbl%0d_strobe", i), int'(got), 1);
      chk($sformatf("tbl%0d_latency", i), lat, 1);
      chk($sformatf("tbl%0d_r", i), r, tbl[i].r);
      chk($sformatf("tbl%0d_c", i), c, tbl[i].c);
      chk($sformatf("tbl%0d_pos", i), int'(dut.pos), tbl[i].pos);
      if (i == 4) chk("tbl4_pred", int'($signed(dut.pred)), 255);
    end

    // Full block of 63 AC coefficients: pos wraps with no EOB.
    send_sym(8'h00, 11'd0, 0, got, lat, r, c);
    chk("blk_dc_c", c, 0);
    for (int k = 0; k < 63; k++) begin
      send_sym(8'h01, 11'b1, 0, got, lat, r, c);
      chk($sformatf("blk_ac%0d", k), (int'(got) << 16) | (r << 8) | (c & 255), (1 << 16) | 1);
    end
    chk("blk_pos_wrap", int'(dut.pos), 0);
    got = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (is_new_coefficient) got = 1'b1;
    end
    chk("blk_no_eob", int'(got), 0);

    // ZRL then an oversized AC symbol: sticky error, no strobe.
    send_sym(8'h00, 11'd0, 0, got, lat, r, c);
    send_sym(8'hF0, 11'd0, 0, got, lat, r, c);
    chk("zrl_r", r, 15);
    chk("zrl_pos", int'(dut.pos), 17);
    send_sym(8'h3B, 11'd0, 0, got, lat, r, c);
    chk("err_no_strobe", int'(got), 0);
    chk("err_flag", int'(error), 1);
    chk("err_rs_ready", int'(rs_ready), 0);
    repeat (3) @(negedge clk);
    chk("err_sticky", int'(error) << 1 | int'(rs_ready), 2);

    do_reset();
    chk("rst2_error", int'(error), 0);
    chk("rst2_rs_ready", int'(rs_ready), 1);

    // Gapped amplitude bits give the same result as back-to-back.
    send_sym(8'h04, 11'b1010, 3, got, lat, r, c);
    chk("gap_strobe", int'(got), 1);
    chk("gap_c", c, 10);
    chk("gap_latency", lat, 1);

    // Reset in the middle of an amplitude.
    rs_symbol = 8'h04; rs_valid = 1'b1;
    @(negedge clk);
    rs_valid = 1'b0; bit_valid = 1'b1; bit_in = 1'b1;
    repeat (2) @(negedge clk);
    bit_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    got = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (is_new_coefficient) got = 1'b1;
    end
    chk("midrst_no_strobe", int'(got), 0);
    chk("midrst_pos", int'(dut.pos), 0);
    chk("midrst_pred", int'(dut.pred), 0);
    chk("midrst_bit_ready", int'(bit_ready), 0);
    chk("midrst_rs_ready", int'(rs_ready), 1);

    // Random legal symbols against the model.
    do_reset();
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 15) == 0) begin
        pulse_clear();
        m_clr = 1'b1;
      end
      if (m_pos == 0) begin
        run = 0; s = $urandom_range(0, 11);
      end else begin
        pick = $urandom_range(0, 9);
        if (pick == 0) begin
          run = 0; s = 0;
        end else if (pick == 1 && m_pos <= 48) begin
          run = 15; s = 0;
        end else begin
          lim = (63 - m_pos < 15) ? 63 - m_pos : 15;
          run = $urandom_range(0, lim); s = $urandom_range(1, 10);
        end
      end
      amp = (s == 0) ? 0 : $urandom_range(0, (1 << s) - 1);
      rs = {run[3:0], s[3:0]};
      model_sym(rs, amp, er, ec);
      send_sym(rs, amp[10:0], ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0,
               got, lat, r, c);
      chk($sformatf("rnd%0d_rs%02h_strobe", k, rs), int'(got), 1);
      chk($sformatf("rnd%0d_rs%02h_r", k, rs), r, er);
      chk($sformatf("rnd%0d_rs%02h_c", k, rs), c, ec);
    end
    chk("rnd_pos", int'(dut.pos), m_pos);
    chk("rnd_error", int'(error), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
